decode_stage: RTL

Registered, parametrised instruction-decode stage for the pipelined MIPS core. It sits between the F/D pipeline register and the register-file read/hazard logic. It accepts up to `LANES` fetched instructions per cycle and decodes each to a 6-bit instruction code. It flags reserved instructions explicitly and buffers results in a two-entry skid buffer with valid/ready handshake and flush.

---
 rtl/decode_stage_pkg.sv | 116 +++++++++++
 rtl/decode_stage_lane_decode.sv | 94 +++++++++
 rtl/decode_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared MIPS instruction codes and opcode/funct/regimm field constants.
package decode_stage_pkg;

  typedef enum logic [5:0] {
    C_SLL     = 6'd0,
    C_SRL     = 6'd1,
    C_SRA     = 6'd2,
    C_SLLV    = 6'd3,
    C_SRLV    = 6'd4,
    C_SRAV    = 6'd5,
    C_JR      = 6'd6,
    C_JALR    = 6'd7,
    C_MFHI    = 6'd8,
    C_MTHI    = 6'd9,
    C_MFLO    = 6'd10,
    C_MTLO    = 6'd11,
    C_MULT    = 6'd12,
    C_MULTU   = 6'd13,
    C_DIV     = 6'd14,
    C_DIVU    = 6'd15,
    C_ADD     = 6'd16,
    C_ADDU    = 6'd17,
    C_SUB     = 6'd18,
    C_SUBU    = 6'd19,
    C_AND     = 6'd20,
    C_OR      = 6'd21,
    C_XOR     = 6'd22,
    C_NOR     = 6'd23,
    C_SLT     = 6'd24,
    C_SLTU    = 6'd25,
    C_BLTZ    = 6'd26,
    C_BGEZ    = 6'd27,
    C_J       = 6'd28,
    C_JAL     = 6'd29,
    C_BEQ     = 6'd30,
    C_BNE     = 6'd31,
    C_BLEZ    = 6'd32,
    C_BGTZ    = 6'd33,
    C_ADDI    = 6'd34,
    C_ADDIU   = 6'd35,
    C_SLTI    = 6'd36,
    C_SLTIU   = 6'd37,
    C_ANDI    = 6'd38,
    C_ORI     = 6'd39,
    C_XORI    = 6'd40,
    C_LUI     = 6'd41,
    C_LB      = 6'd42,
    C_LH      = 6'd43,
    C_LW      = 6'd44,
    C_LBU     = 6'd45,
    C_LHU     = 6'd46,
    C_SB      = 6'd47,
    C_SH      = 6'd48,
    C_SW      = 6'd49,
    C_ILLEGAL = 6'd63
  } instr_code_e;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct field
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // REGIMM rt field
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

endpackage

// File: rtl/decode_stage_lane_decode.sv
// Combinational decode of one 32-bit MIPS word to an instruction code.
module instr_lane_decode
  import decode_stage_pkg::*;
#(
  parameter int unsigned CODE_W = 6
) (
  input  logic [31:0]       instr,
  output logic [CODE_W-1:0] code,
  output logic              ri
);

  instr_code_e c;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic        unused_fields;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign unused_fields = ^{instr[25:21], instr[15:6]};

  // Map opcode / funct / regimm rt to a code; anything unlisted is ILLEGAL
  always_comb begin
    c = C_ILLEGAL;
    case (op)
      OP_SPECIAL: begin
        case (fn)
          FN_SLL:   c = C_SLL;
          FN_SRL:   c = C_SRL;
          FN_SRA:   c = C_SRA;
          FN_SLLV:  c = C_SLLV;
          FN_SRLV:  c = C_SRLV;
          FN_SRAV:  c = C_SRAV;
          FN_JR:    c = C_JR;
          FN_JALR:  c = C_JALR;
          FN_MFHI:  c = C_MFHI;
          FN_MTHI:  c = C_MTHI;
          FN_MFLO:  c = C_MFLO;
          FN_MTLO:  c = C_MTLO;
          FN_MULT:  c = C_MULT;
          FN_MULTU: c = C_MULTU;
          FN_DIV:   c = C_DIV;
          FN_DIVU:  c = C_DIVU;
          FN_ADD:   c = C_ADD;
          FN_ADDU:  c = C_ADDU;
          FN_SUB:   c = C_SUB;
          FN_SUBU:  c = C_SUBU;
          FN_AND:   c = C_AND;
          FN_OR:    c = C_OR;
          FN_XOR:   c = C_XOR;
          FN_NOR:   c = C_NOR;
          FN_SLT:   c = C_SLT;
          FN_SLTU:  c = C_SLTU;
          default:  c = C_ILLEGAL;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ: c = C_BLTZ;
          RT_BGEZ: c = C_BGEZ;
          default: c = C_ILLEGAL;
        endcase
      end
      OP_J:     c = C_J;
      OP_JAL:   c = C_JAL;
      OP_BEQ:   c = C_BEQ;
      OP_BNE:   c = C_BNE;
      OP_BLEZ:  c = C_BLEZ;
      OP_BGTZ:  c = C_BGTZ;
      OP_ADDI:  c = C_ADDI;
      OP_ADDIU: c = C_ADDIU;
      OP_SLTI:  c = C_SLTI;
      OP_SLTIU: c = C_SLTIU;
      OP_ANDI:  c = C_ANDI;
      OP_ORI:   c = C_ORI;
      OP_XORI:  c = C_XORI;
      OP_LUI:   c = C_LUI;
      OP_LB:    c = C_LB;
      OP_LH:    c = C_LH;
      OP_LW:    c = C_LW;
      OP_LBU:   c = C_LBU;
      OP_LHU:   c = C_LHU;
      OP_SB:    c = C_SB;
      OP_SH:    c = C_SH;
      OP_SW:    c = C_SW;
      default:  c = C_ILLEGAL;
    endcase
  end

  assign code = CODE_W'(c);
  assign ri   = (c == C_ILLEGAL);

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: per-lane decode feeding a two-entry skid buffer
// (main drives the outputs, skid absorbs one beat of backpressure).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned LANES  = 1,
  parameter int unsigned CODE_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*LANES-1:0]      in_instr,
  input  logic [31:0]              in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CODE_W*LANES-1:0]  out_code,
  output logic [32*LANES-1:0]      out_instr,
  output logic [31:0]              out_pc,
  output logic [LANES-1:0]         out_ri,
  output logic [15:0]              ri_count
);

  logic [CODE_W*LANES-1:0] dec_code, main_code, skid_code;
  logic [LANES-1:0]        dec_ri, main_ri, skid_ri;
  logic [32*LANES-1:0]     main_instr, skid_instr;
  logic [31:0]             main_pc, skid_pc;
  logic                    main_valid, skid_valid;
  logic                    accept, drain, load_main;
  logic [16:0]             ri_sum;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    instr_lane_decode #(.CODE_W(CODE_W)) u_dec (
      .instr (in_instr[32*g +: 32]),
      .code  (dec_code[CODE_W*g +: CODE_W]),
      .ri    (dec_ri[g])
    );
  end

  // Handshake qualifiers and the saturating-counter increment
  always_comb begin
    in_ready  = !skid_valid;
    accept    = in_valid && !skid_valid;
    drain     = main_valid && out_ready;
    load_main = !main_valid || out_ready;
    ri_sum    = {1'b0, ri_count};
    for (int unsigned i = 0; i < LANES; i++) begin
      if (main_ri[i]) ri_sum = ri_sum + 17'd1;
    end
  end

  // Skid buffer: skid refills main first; a new beat can only arrive when
  // skid is empty, so the two loads into main never collide
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_code  <= '0;
      main_instr <= '0;
      main_pc    <= '0;
      main_ri    <= '0;
      skid_code  <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_ri    <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_main) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_code  <= skid_code;
        main_instr <= skid_instr;
        main_pc    <= skid_pc;
        main_ri    <= skid_ri;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_code  <= dec_code;
        main_instr <= in_instr;
        main_pc    <= in_pc;
        main_ri    <= dec_ri;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_code  <= dec_code;
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
      skid_ri    <= dec_ri;
    end
  end

  // Count reserved lanes on each delivered beat, clamping at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      ri_count <= '0;
    end else if (drain) begin
      ri_count <= ri_sum[16] ? 16'hFFFF : ri_sum[15:0];
    end
  end

  assign out_valid = main_valid;
  assign out_code  = main_code;
  assign out_instr = main_instr;
  assign out_pc    = main_pc;
  assign out_ri    = main_ri;

endmodule
